// File: rtl/wb_slave_router_if.sv
//------------------------------------------------------------------------------
// Module      : wb_slave_router_if
// Description : Wishbone slave-port and peripheral-channel bundle for the router.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_slave_router_if #(
  parameter int N_SLV = 5
);
  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_dat_i;
  logic [31:0]            wbs_adr_i;
  logic                   wbs_ack_o;
  logic                   wbs_err_o;
  logic [31:0]            wbs_dat_o;
  logic [N_SLV-1:0]       slv_valid_o;
  logic [N_SLV-1:0]       slv_ack_i;
  logic [32*N_SLV-1:0]    slv_dat_i;
  logic [15:0]            err_cnt_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  slv_ack_i, slv_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o, slv_valid_o, err_cnt_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output slv_ack_i, slv_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o, slv_valid_o, err_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_slave_router.sv
//------------------------------------------------------------------------------
// Module      : wb_slave_router
// Description : Base/mask Wishbone address router with timeout and bus-error reply.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_slave_router #(
  parameter int                  N_SLV    = 5,
  parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0}},
  parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'h0}},
  parameter int                  TIMEOUT  = 255,
  parameter logic [31:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_slave_router_if.slave   bus
);

  localparam int               c_SEL_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [15:0]      c_TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [N_SLV-1:0] c_ONE      = N_SLV'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [15:0]          r_timer, w_timer_nxt;
  logic                 r_err, w_err_nxt;
  logic [31:0]          r_dat, w_dat_nxt;
  logic [15:0]          r_err_cnt, w_err_cnt_nxt;
  logic [15:0]          w_err_cnt_inc;

  logic [N_SLV-1:0]     w_hit;
  logic                 w_any_hit;
  logic [c_SEL_W-1:0]   w_hit_idx;
  logic                 w_sel_ack;
  logic [31:0]          w_sel_dat;

  generate
    for (genvar i = 0; i < N_SLV; i++) begin : g_match
      assign w_hit[i] = ((bus.wbs_adr_i & SLV_MASK[32*i +: 32]) ==
                         (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]));
    end
  endgenerate

  // Scan downward so the lowest-numbered hit is the one left standing.
  always_comb begin
    w_any_hit = |w_hit;
    w_hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_idx = c_SEL_W'(i);
      end
    end
  end

  assign w_sel_ack     = bus.slv_ack_i[r_sel];
  assign w_sel_dat     = bus.slv_dat_i[32*r_sel +: 32];
  assign w_err_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_timer_nxt   = r_timer;
    w_err_nxt     = r_err;
    w_dat_nxt     = r_dat;
    w_err_cnt_nxt = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (w_any_hit) begin
            w_sel_nxt   = w_hit_idx;
            w_timer_nxt = '0;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_BUSY;
          end else begin
            w_err_nxt     = 1'b1;
            w_dat_nxt     = ERR_DATA;
            w_err_cnt_nxt = w_err_cnt_inc;
            w_state_nxt   = S_RESP;
          end
        end
      end
      S_BUSY: begin
        // A master that has dropped cyc gets no reply, even if the slave acks now.
        if (!bus.wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_ack) begin
          w_dat_nxt   = w_sel_dat;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_timer == c_TMO_LAST) begin
          w_err_nxt     = 1'b1;
          w_dat_nxt     = ERR_DATA;
          w_err_cnt_nxt = w_err_cnt_inc;
          w_state_nxt   = S_RESP;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_timer   <= '0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_timer   <= w_timer_nxt;
      r_err     <= w_err_nxt;
      r_dat     <= w_dat_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bus.slv_valid_o = (r_state == S_BUSY) ? (c_ONE << r_sel) : '0;
  assign bus.wbs_ack_o   = (r_state == S_RESP);
  assign bus.wbs_err_o   = (r_state == S_RESP) && r_err;
  assign bus.wbs_dat_o   = (r_state == S_RESP) ? r_dat : 32'h0;
  assign bus.err_cnt_o   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_router.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_slave_router
// Description : Directed self-checking bench for wb_slave_router.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_slave_router;

  localparam int N_SLV = 5;
  localparam logic [32*N_SLV-1:0] c_BASE = {32'h4000_0000, 32'h1000_0000, 32'h3000_1000,
                                            32'h2000_0000, 32'h1000_0000};
  localparam logic [32*N_SLV-1:0] c_MASK = {32'hFF00_0000, 32'hF000_0000, 32'hFF00_F000,
                                            32'hFF00_0000, 32'hFF00_0000};
  localparam logic [31:0] c_ERR = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wb_slave_router_if #(.N_SLV(N_SLV)) bus ();

  wb_slave_router #(
    .N_SLV    (N_SLV),
    .SLV_BASE (c_BASE),
    .SLV_MASK (c_MASK),
    .TIMEOUT  (8),
    .ERR_DATA (c_ERR)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
  endtask

  task automatic drop();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic err, input logic [31:0] dat);
    chk({tag, "_ack"},   32'(bus.wbs_ack_o),   32'd1);
    chk({tag, "_err"},   32'(bus.wbs_err_o),   32'(err));
    chk({tag, "_dat"},   bus.wbs_dat_o,        dat);
    chk({tag, "_valid"}, 32'(bus.slv_valid_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drop();
    bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_adr_i = 32'h0;
    bus.slv_ack_i = '0;
    bus.slv_dat_i = {32'hA000_0004, 32'hA000_0003, 32'h1234_5678, 32'hA000_0001, 32'hA000_0000};
    tick();
    tick();
    chk("rst_ack",   32'(bus.wbs_ack_o),   32'd0);
    chk("rst_err",   32'(bus.wbs_err_o),   32'd0);
    chk("rst_dat",   bus.wbs_dat_o,        32'd0);
    chk("rst_valid", 32'(bus.slv_valid_o), 32'd0);
    chk("rst_cnt",   32'(bus.err_cnt_o),   32'd0);
    rst = 1'b0;
    tick();

    // Slave 2 read, acked in the third valid cycle.
    req(32'h3000_1004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_valid", 32'(bus.slv_valid_o), 32'b00100);
      chk("rd_noack", 32'(bus.wbs_ack_o),   32'd0);
    end
    bus.slv_ack_i = 5'b00100;
    tick();
    chk_resp("rd", 1'b0, 32'h1234_5678);
    bus.slv_ack_i = '0;
    drop();
    tick();
    chk("rd_idle_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rd_idle_dat", bus.wbs_dat_o,      32'd0);

    // Unmapped address.
    req(32'h5000_0000, 1'b0);
    tick();
    chk_resp("unm", 1'b1, c_ERR);
    chk("unm_cnt", 32'(bus.err_cnt_o), 32'd1);
    drop();
    tick();
    chk("unm_idle_ack", 32'(bus.wbs_ack_o), 32'd0);

    // Silent slave: 8 valid cycles then error reply.
    req(32'h3000_1004, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("tmo_valid", 32'(bus.slv_valid_o), 32'b00100);
      tick();
    end
    chk_resp("tmo", 1'b1, c_ERR);
    chk("tmo_cnt", 32'(bus.err_cnt_o), 32'd2);
    drop();
    tick();

    // Ack on the same cycle the timeout would fire.
    req(32'h3000_1004, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("coin_valid", 32'(bus.slv_valid_o), 32'b00100);
    bus.slv_ack_i = 5'b00100;
    tick();
    chk_resp("coin", 1'b0, 32'h1234_5678);
    chk("coin_cnt", 32'(bus.err_cnt_o), 32'd2);
    bus.slv_ack_i = '0;
    drop();
    tick();

    // Overlapping maps 0 and 3, stray ack on slave 4, address change ignored.
    req(32'h1000_0010, 1'b0);
    tick();
    chk("ovl_valid", 32'(bus.slv_valid_o), 32'b00001);
    bus.slv_ack_i = 5'b10000;
    bus.wbs_adr_i = 32'h3000_1004;
    tick();
    chk("ovl_stray_valid", 32'(bus.slv_valid_o), 32'b00001);
    chk("ovl_stray_ack",   32'(bus.wbs_ack_o),   32'd0);
    bus.slv_ack_i = 5'b00001;
    tick();
    chk_resp("ovl", 1'b0, 32'hA000_0000);
    bus.slv_ack_i = '0;
    drop();
    tick();

    // Master abort in the second BUSY cycle.
    req(32'h2000_0000, 1'b0);
    tick();
    chk("abt_valid", 32'(bus.slv_valid_o), 32'b00010);
    tick();
    drop();
    tick();
    chk("abt_valid_off", 32'(bus.slv_valid_o), 32'd0);
    chk("abt_ack",       32'(bus.wbs_ack_o),   32'd0);
    tick();
    chk("abt_ack2", 32'(bus.wbs_ack_o), 32'd0);
    chk("abt_cnt",  32'(bus.err_cnt_o), 32'd2);

    // Reset while BUSY.
    req(32'h2000_0000, 1'b0);
    tick();
    chk("rsb_valid", 32'(bus.slv_valid_o), 32'b00010);
    rst = 1'b1;
    tick();
    chk("rsb_valid_off", 32'(bus.slv_valid_o), 32'd0);
    chk("rsb_ack",       32'(bus.wbs_ack_o),   32'd0);
    chk("rsb_dat",       bus.wbs_dat_o,        32'd0);
    chk("rsb_cnt",       32'(bus.err_cnt_o),   32'd0);
    rst = 1'b0;
    drop();
    tick();

    // Counter saturation from a preloaded value, with error writes.
    force dut.r_err_cnt = 16'hFFFD;
    #1;
    release dut.r_err_cnt;
    chk("sat_pre", 32'(bus.err_cnt_o), 32'h0000_FFFD);
    for (int i = 0; i < 3; i++) begin
      req(32'h5000_0000, 1'b1);
      tick();
      chk_resp("sat", 1'b1, c_ERR);
      chk("sat_cnt", 32'(bus.err_cnt_o), (i == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
      drop();
      tick();
    end
    chk("sat_hold", 32'(bus.err_cnt_o), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
